// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, op encoding and helpers for the RV64M multiply/divide unit
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int ITER_CNT_64 = 64;
  localparam int ITER_CNT_32 = 32;

  localparam logic [63:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// rtl/muldiv_iter_datapath.sv - 129-bit shift register with one 65-bit add/sub step per cycle
module muldiv_iter_datapath (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         mode_div_i,
  input  logic [128:0] p_init_i,
  input  logic [63:0]  opb_i,
  output logic [128:0] p_o
);

  logic [128:0] p_q, p_d;
  logic [63:0]  b_q;
  logic [64:0]  a65, b65, sum65;
  logic         borrow;

  // Multiply: conditional add of the multiplicand then shift right.
  // Divide: shift left, trial-subtract the divisor, restore on borrow.
  always_comb begin
    a65    = mode_div_i ? p_q[127:63] : p_q[128:64];
    b65    = mode_div_i ? ~{1'b0, b_q} : (p_q[0] ? {1'b0, b_q} : 65'd0);
    sum65  = a65 + b65 + {64'd0, mode_div_i};
    borrow = sum65[64];
    p_d    = p_q;
    if (load_i) begin
      p_d = p_init_i;
    end else if (step_i) begin
      if (mode_div_i) begin
        p_d = {(borrow ? a65 : sum65), p_q[62:0], ~borrow};
      end else begin
        p_d = {1'b0, sum65, p_q[63:1]};
      end
    end
  end

  // Working register and fixed second operand.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= '0;
      b_q <= '0;
    end else begin
      p_q <= p_d;
      if (load_i) b_q <= opb_i;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/muldiv_unit_64bit.sv
// rtl/muldiv_unit_64bit.sv - iterative RV64M mul/div unit; MULDIV_WORD_OPS_EN enables the W-form ops
import muldiv_pkg::*;

module muldiv_unit_64bit (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  muldiv_op_e       op_in, op_q;
  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d, cnt_last;
  logic             word_in, word_q, neg_in, neg_q;
  logic [TAG_W-1:0] rd_q, rd_out_q;
  logic [63:0]      result_q;
  logic             accept, fast, load_res, unused_bits;
  logic             signed_a, signed_b, a_neg, b_neg, is_div, is_rem, div0, ovf;
  logic [63:0]      a_val, b_val, a_mag, b_mag, dividend_res, fast_res;
  logic [128:0]     p_init, p_w;
  logic [63:0]      opb_init;
  logic [127:0]     prod, prod_s;
  logic [63:0]      mul_res, quo, rem, div_mag, div_s, raw, fix_res;

  assign op_in = muldiv_op_e'(op[2:0]);

`ifdef MULDIV_WORD_OPS_EN
  assign word_in     = op[3] & ((op_in == OP_MUL) | op[2]);
  assign unused_bits = p_w[128];
`else
  assign word_in     = 1'b0;
  assign unused_bits = p_w[128] ^ op[3];
`endif

  // Operand magnitudes, sign of the final result and fast-path detection at request time.
  always_comb begin
    signed_a     = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b     = op_in inside {OP_MULH, OP_DIV, OP_REM};
    is_div       = op[2];
    is_rem       = op[1];
    a_val        = word_in ? (signed_a ? sext32(rs1_data[31:0]) : {32'd0, rs1_data[31:0]}) : rs1_data;
    b_val        = word_in ? (signed_b ? sext32(rs2_data[31:0]) : {32'd0, rs2_data[31:0]}) : rs2_data;
    a_neg        = signed_a & a_val[63];
    b_neg        = signed_b & b_val[63];
    a_mag        = a_neg ? -a_val : a_val;
    b_mag        = b_neg ? -b_val : b_val;
    neg_in       = (is_div & is_rem) ? a_neg : (a_neg ^ b_neg);
    div0         = word_in ? (rs2_data[31:0] == 32'd0) : (rs2_data == 64'd0);
    ovf          = (op_in inside {OP_DIV, OP_REM}) &
                   (word_in ? ((rs1_data[31:0] == INT32_MIN) && (rs2_data[31:0] == ALL_ONES[31:0]))
                            : ((rs1_data == INT64_MIN) && (rs2_data == ALL_ONES)));
    fast         = is_div & (div0 | ovf);
    dividend_res = word_in ? sext32(rs1_data[31:0]) : rs1_data;
    if (div0) fast_res = is_rem ? dividend_res : ALL_ONES;
    else      fast_res = is_rem ? 64'd0 : dividend_res;
    if (is_div) begin
      p_init   = word_in ? {65'd0, a_mag[31:0], 32'd0} : {65'd0, a_mag};
      opb_init = b_mag;
    end else begin
      p_init   = word_in ? {97'd0, b_mag[31:0]} : {65'd0, b_mag};
      opb_init = a_mag;
    end
  end

  assign accept = (state_q == ST_IDLE) & start & ~kill;

  muldiv_iter_datapath u_dp (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (accept),
    .step_i     (state_q == ST_CALC),
    .mode_div_i (op_q[2]),
    .p_init_i   (p_init),
    .opb_i      (opb_init),
    .p_o        (p_w)
  );

  // Sign correction and half / quotient / remainder selection applied in FIX.
  always_comb begin
    prod    = word_q ? {64'd0, p_w[95:32]} : p_w[127:0];
    prod_s  = neg_q ? -prod : prod;
    mul_res = (op_q == OP_MUL) ? prod_s[63:0] : prod_s[127:64];
    quo     = word_q ? {32'd0, p_w[31:0]} : p_w[63:0];
    rem     = p_w[127:64];
    div_mag = op_q[1] ? rem : quo;
    div_s   = neg_q ? -div_mag : div_mag;
    raw     = op_q[2] ? div_s : mul_res;
    fix_res = word_q ? sext32(raw[31:0]) : raw;
  end

  // Next-state logic; kill aborts any in-flight operation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_last = word_q ? 6'(ITER_CNT_32 - 1) : 6'(ITER_CNT_64 - 1);
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = fast ? ST_DONE : ST_CALC;
        cnt_d   = 6'd0;
      end
      ST_CALC: if (cnt_q == cnt_last) state_d = ST_FIX;
               else cnt_d = cnt_q + 6'd1;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (kill && (state_q != ST_IDLE)) state_d = ST_IDLE;
    load_res = (accept & fast) | ((state_q == ST_FIX) & ~kill);
  end

  // Control and result registers; outputs only change on a completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= op_in;
        word_q <= word_in;
        neg_q  <= neg_in;
        rd_q   <= rd_in;
      end
      if (load_res) begin
        result_q <= accept ? fast_res : fix_res;
        rd_out_q <= accept ? rd_in : rd_q;
      end
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit_64bit.sv
// tb/tb_muldiv_unit_64bit.sv - directed self-checking bench for muldiv_unit_64bit
module tb_muldiv_unit_64bit;

  logic        clk = 1'b0;
  logic        reset_n, start, kill;
  logic [3:0]  op;
  logic [63:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit_64bit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_low);
    lat = lat0;
    busy_low = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_low++;
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd,
                     input logic [63:0] exp_res, input int exp_lat);
    int lat, bl;
    issue(o, a, b, rd);
    wait_done(1, lat, bl);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_low"}, 64'(bl), 64'd0);
    check({tag, "_rd_out"}, {59'd0, rd_out}, {59'd0, rd});
    tick();
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bl, seen;
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_rd_out", {59'd0, rd_out}, 64'd0);
    reset_n = 1'b1;
    tick();

    run("mul", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    run("mulhu", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("mulh", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd0, 66);
    run("mulhsu", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run("div", 4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd10, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    run("rem", 4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("divu", 4'd5, 64'd100, 64'd7, 5'd17, 64'hE, 66);
    repeat (3) tick();
    check("hold_result", result, 64'hE);
    check("hold_rd_out", {59'd0, rd_out}, 64'd17);

    run("divu_by0", 4'd5, 64'd100, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_by0", 4'd7, 64'd100, 64'd0, 5'd13, 64'h64, 1);
    run("div_ovf", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 1);

    // second start while busy must be ignored
    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    repeat (9) tick();
    op = 4'd5; rs1_data = 64'd100; rs2_data = 64'd0; rd_in = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(11, lat, bl);
    check("ignored_start_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("ignored_start_latency", 64'(lat), 64'd66);
    check("ignored_start_rd_out", {59'd0, rd_out}, 64'd9);
    tick();
    check("ignored_start_idle", {62'd0, busy, done}, 64'd0);

    // kill mid-calculation
    issue(4'd5, 64'd100, 64'd7, 5'd2);
    repeat (19) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (80) begin
      if (done === 1'b1) seen++;
      tick();
    end
    check("kill_no_done", 64'(seen), 64'd0);
    check("kill_result_held", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("kill_rd_held", {59'd0, rd_out}, 64'd9);

    // kill together with start in IDLE
    op = 4'd5; rs1_data = 64'd100; rs2_data = 64'd0; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", {62'd0, busy, done}, 64'd0);
    check("kill_start_result", result, 64'hFFFF_FFFF_FFFF_FFEB);

    // asynchronous reset mid-calculation
    issue(4'd0, 64'd7, 64'd3, 5'd4);
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("async_reset_result", result, 64'd0);
    check("async_reset_rd_out", {59'd0, rd_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run("divu_after_reset", 4'd5, 64'd100, 64'd7, 5'd17, 64'hE, 66);

`ifdef MULDIV_WORD_OPS_EN
    run("divw_ovf", 4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd20, 64'hFFFF_FFFF_8000_0000, 1);
    run("mulw", 4'b1000, 64'h1_0000_0003, 64'd5, 5'd21, 64'hF, 34);
    run("remw", 4'b1110, 64'hFFFF_FFEC, 64'd3, 5'd22, 64'hFFFF_FFFF_FFFF_FFFE, 34);
`else
    run("div_w_ignored", 4'b1100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd20, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    run("divw_as_div", 4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd21, 64'd0, 66);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
